cplx_mag_sched: RTL and testbench
=================================

Name: cplx_mag_sched

Overview:
- Scheduler that shares one iterative sqrt_datapath instance between two complex-operand requesters (A and B) for polar-magnitude conversion.
- Accepts an operand pair, forms re²+im², sequences the sqrt unit's start/stop pulses, captures the root and returns the magnitude with a source tag.
- Sits between the operand-supply logic and the single shared sqrt_datapath, so the polar path needs one sqrt core instead of two.

Parameters:
- SQRT_CYCLES, 32, clock cycles the sqrt_datapath needs between the start pulse and a valid stop; legal range 1..255.

Ports:
- clock  in  1  master clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- a_valid  in  1  requester A has an operand.
- a_ready  out  1  A operand accepted this cycle when a_valid&a_ready.
- a_re  in  32  A real part, two's complement.
- a_im  in  32  A imaginary part, two's complement.
- b_valid  in  1  requester B has an operand.
- b_ready  out  1  B accept strobe, same rules as a_ready.
- b_re  in  32  B real part, two's complement.
- b_im  in  32  B imaginary part, two's complement.
- res_valid  out  1  magnitude result available.
- res_ready  in  1  consumer accepts the result.
- res_mag  out  32  floor(sqrt(re²+im²)), unsigned.
- res_src  out  1  0 = result for A, 1 = result for B.
- busy  out  1  high in every state except IDLE.
- sq_start  out  1  one-cycle start pulse to sqrt_datapath.
- sq_stop  out  1  one-cycle stop pulse; the sqrt unit loads its output register.
- sq_xin  out  64  sqrt argument, registered.
- sq_root  in  32  sqrt result from sqrt_datapath; valid the cycle after sq_stop.

Behaviour:
- States: IDLE, SQUARE, START, WAIT, STOP, LOAD, DONE.
- Reset values: all outputs 0, state IDLE, wait counter 0, last_grant = B (so A wins the first tie).

IDLE:
- a_ready/b_ready are combinational, asserted only in IDLE, and at most one is high.
- One valid requester: that requester gets ready.
- Both valid: grant goes to the requester not in last_grant (round robin).
- On accept, latch re/im and the source, update last_grant, and go to SQUARE.

Sequencing, with accept in cycle t:
- SQUARE (t+1): sq_xin <= re*re + im*im.
  - Signed 32x32 products are non-negative.
  - The sum is computed in 64-bit unsigned; max 2^63 at (-2^31,-2^31), no overflow.
- START (t+2): sq_start=1 for exactly one cycle; counter loads SQRT_CYCLES-1.
- WAIT: lasts exactly SQRT_CYCLES cycles; counter decrements to 0.
- STOP: sq_stop=1 for exactly one cycle.
- LOAD: res_mag <= sq_root, res_src <= latched source.
- DONE: res_valid=1, first at t+SQRT_CYCLES+5 (t+37 at default).

Output handshake:
- In DONE, res_mag and res_src hold stable while res_valid&!res_ready.
- On res_valid&res_ready, res_valid drops next cycle and state returns to IDLE.
- No new accept in the same cycle as result handoff; minimum spacing between accepts is SQRT_CYCLES+6 cycles.

Invariants and boundary conditions:
- sq_xin is held constant from SQUARE through STOP; sq_start and sq_stop are never high together.
- Requester valid deasserting outside IDLE has no effect; operands are already latched.
- A requester must hold valid until ready; operand changes while unaccepted are allowed.
- Zero operand (0,0): sq_xin=0, res_mag=0, normal latency.
- Reset asserted in any state: next cycle all outputs 0, state IDLE, last_grant=B.
  - Any in-flight result is discarded.
  - No sq_stop is issued for the aborted operation; the sqrt unit is reset by the same reset.

Test Plan:
- A valid with (3,4), res_ready=1 → a_ready high in the accept cycle, sq_start at t+2, sq_stop at t+35, res_valid at t+37 with res_mag=5, res_src=0; uses a behavioural sqrt model with SQRT_CYCLES=32.
- B only with (-5,-12) → b_ready only, sq_xin=169, res_mag=13, res_src=1.
- a_valid and b_valid held high for 4 requests → grant order A,B,A,B; a_ready and b_ready never high together; busy low only between jobs.
- (-2^31,-2^31) → sq_xin=64'h8000_0000_0000_0000, res_mag=3037000499; (7,7) → res_mag=9 (floor).
- res_ready held low 10 cycles in DONE → res_valid, res_mag and res_src stable, a_ready low throughout, then handoff and return to IDLE.
- reset pulsed during WAIT → next cycle busy=0, sq_start/sq_stop=0, res_valid=0; next request completes correctly, and A wins the tie.

Source files
------------

// File: rtl/cplx_mag_sched.sv
// cplx_mag_sched: arbitrates two complex-operand requesters onto one shared
//   iterative sqrt_datapath and returns floor(sqrt(re^2+im^2)) with a source tag.
// Latency: accept in cycle t -> res_valid first high in cycle t+SQRT_CYCLES+5.
// Backpressure: a_ready/b_ready only in IDLE (one job in flight); result is held
//   in DONE until res_ready, and no new operand is accepted until handoff.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   a_valid/a_ready/a_re/a_im   requester A operand handshake (two's complement)
//   b_valid/b_ready/b_re/b_im   requester B operand handshake (two's complement)
//   res_valid/res_ready/res_mag/res_src   result handshake; src 0 = A, 1 = B
//   busy                  high whenever the scheduler is not IDLE
//   sq_start/sq_stop/sq_xin/sq_root   control/data to the shared sqrt_datapath
module cplx_mag_sched #(
  parameter int unsigned SQRT_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_re,
  input  logic [31:0] b_im,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_mag,
  output logic        res_src,
  output logic        busy,
  output logic        sq_start,
  output logic        sq_stop,
  output logic [63:0] sq_xin,
  input  logic [31:0] sq_root
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SQUARE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STOP   = 3'd4,
    ST_LOAD   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // WAIT exits when the counter reaches zero, so loading N-1 gives N cycles.
  localparam logic [7:0] CNT_INIT = 8'(SQRT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last_grant;  // 0 = A was granted last, 1 = B
  logic        r_src;         // source of the job in flight
  logic [31:0] r_re;
  logic [31:0] r_im;
  logic [7:0]  r_cnt;
  logic [63:0] r_xin;
  logic [31:0] r_mag;
  logic        r_res_src;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_accept;

  logic signed [63:0] w_re_ext;
  logic signed [63:0] w_im_ext;
  logic signed [63:0] w_re_sq;
  logic signed [63:0] w_im_sq;
  logic [63:0]        w_sum;

  // Round robin: A wins a tie only when B was granted last. Exactly one of
  // the two grants can be high, so the ready outputs are mutually exclusive.
  assign w_grant_a = a_valid & (~b_valid | r_last_grant);
  assign w_grant_b = b_valid & ~w_grant_a;

  // Squares of sign-extended operands are non-negative and at most 2^62, so
  // their unsigned sum tops out at 2^63 and never wraps in 64 bits.
  assign w_re_ext = {{32{r_re[31]}}, r_re};
  assign w_im_ext = {{32{r_im[31]}}, r_im};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;
  assign w_sum    = $unsigned(w_re_sq) + $unsigned(w_im_sq);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    w_state_nxt = r_state;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    w_accept    = 1'b0;
    busy        = 1'b1;
    sq_start    = 1'b0;
    sq_stop     = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy     = 1'b0;
        a_ready  = w_grant_a;
        b_ready  = w_grant_b;
        w_accept = w_grant_a | w_grant_b;
        if (w_accept) begin
          w_state_nxt = ST_SQUARE;
        end
      end
      ST_SQUARE: begin
        w_state_nxt = ST_START;
      end
      ST_START: begin
        sq_start    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        sq_stop     = 1'b1;
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // sq_root is valid the cycle after sq_stop, i.e. now.
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand latch, sqrt argument, wait counter and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_src        <= 1'b0;
      r_re         <= 32'd0;
      r_im         <= 32'd0;
      r_cnt        <= 8'd0;
      r_xin        <= 64'd0;
      r_mag        <= 32'd0;
      r_res_src    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_re         <= w_grant_a ? a_re : b_re;
        r_im         <= w_grant_a ? a_im : b_im;
        r_src        <= w_grant_b;
        r_last_grant <= w_grant_b;
      end

      // Written only in SQUARE, so the argument stays put through STOP.
      if (r_state == ST_SQUARE) begin
        r_xin <= w_sum;
      end

      if (r_state == ST_START) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end

      // Loaded only in LOAD, so the result is stable while DONE is stalled.
      if (r_state == ST_LOAD) begin
        r_mag     <= sq_root;
        r_res_src <= r_src;
      end
    end
  end

  assign sq_xin  = r_xin;
  assign res_mag = r_mag;
  assign res_src = r_res_src;

endmodule

// File: tb/tb_cplx_mag_sched.sv
module tb_cplx_mag_sched;
  localparam int N = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic        res_valid, res_ready, res_src, busy, sq_start, sq_stop;
  logic [31:0] res_mag;
  logic [63:0] sq_xin;
  logic [31:0] sq_root;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] mag;
    logic        src;
  } exp_t;
  exp_t sb[$];

  // operand tables for multi-job scenarios
  logic [31:0] ta_re[4], ta_im[4], ta_mag[4];
  logic [31:0] tb_re[4], tb_im[4], tb_mag[4];

  always #5 clock = ~clock;

  cplx_mag_sched #(.SQRT_CYCLES(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_re      (b_re),
    .b_im      (b_im),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_mag   (res_mag),
    .res_src   (res_src),
    .busy      (busy),
    .sq_start  (sq_start),
    .sq_stop   (sq_stop),
    .sq_xin    (sq_xin),
    .sq_root   (sq_root)
  );

  function automatic logic [31:0] isqrt(input logic [63:0] x);
    logic [31:0] r;
    logic [63:0] t;
    r = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      t = {32'd0, (r | (32'd1 << i))};
      if (t * t <= x) r = r | (32'd1 << i);
    end
    return r;
  endfunction

  // Behavioural sqrt unit: loads its output on stop, only if it was started.
  logic m_started;
  logic [31:0] m_root;
  always @(posedge clock) begin
    if (reset) begin
      m_started <= 1'b0;
      m_root    <= 32'd0;
    end else begin
      if (sq_start) m_started <= 1'b1;
      if (sq_stop) begin
        m_root    <= m_started ? isqrt(sq_xin) : 32'hDEAD_BEEF;
        m_started <= 1'b0;
      end
    end
  end
  assign sq_root = m_root;

  // Single job with cycle-exact timing checks; caller is at a negedge.
  task automatic run_job(input logic src, input logic [31:0] re, input logic [31:0] im,
                         input logic [63:0] exp_xin, input logic [31:0] exp_mag,
                         input string name);
    exp_t e;
    logic rdy, other, both;
    logic [31:0] got_mag;
    logic got_src;
    int st, sp, rv;
    e.mag = exp_mag;
    e.src = src;
    sb.push_back(e);
    res_ready = 1'b1;
    if (src) begin b_valid = 1'b1; b_re = re; b_im = im; end
    else     begin a_valid = 1'b1; a_re = re; a_im = im; end
    rdy = 1'b0;
    other = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      rdy   = src ? b_ready : a_ready;
      other = src ? a_ready : b_ready;
      if (rdy === 1'b1) break;
      @(negedge clock);
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b want 1", name, rdy);
      e = sb.pop_back();
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    checks++;
    if (other !== 1'b0) begin errors++; $display("FAIL %s_other_ready: got %b want 0", name, other); end
    st = -1; sp = -1; rv = -1; both = 1'b0;
    got_mag = 32'd0; got_src = 1'b0;
    for (int c = 1; c <= N + 20 && rv < 0; c++) begin
      @(negedge clock);
      if (c == 1) begin a_valid = 1'b0; b_valid = 1'b0; end
      #1;
      if (sq_start === 1'b1 && st < 0) st = c;
      if (sq_stop === 1'b1 && sp < 0) sp = c;
      if (sq_start === 1'b1 && sq_stop === 1'b1) both = 1'b1;
      if (c == 2) begin
        checks++;
        if (sq_xin !== exp_xin) begin errors++; $display("FAIL %s_xin: got %h want %h", name, sq_xin, exp_xin); end
      end
      if (res_valid === 1'b1) begin rv = c; got_mag = res_mag; got_src = res_src; end
    end
    checks++;
    if (st != 2) begin errors++; $display("FAIL %s_start_cycle: got %0d want 2", name, st); end
    checks++;
    if (sp != N + 3) begin errors++; $display("FAIL %s_stop_cycle: got %0d want %0d", name, sp, N + 3); end
    checks++;
    if (both) begin errors++; $display("FAIL %s_start_stop_overlap: got 1 want 0", name); end
    checks++;
    if (rv != N + 5) begin errors++; $display("FAIL %s_res_cycle: got %0d want %0d", name, rv, N + 5); end
    if (rv < 0) begin
      e = sb.pop_front();
      return;
    end
    e = sb.pop_front();
    checks++;
    if (got_mag !== e.mag) begin errors++; $display("FAIL %s_mag: got %0d want %0d", name, got_mag, e.mag); end
    checks++;
    if (got_src !== e.src) begin errors++; $display("FAIL %s_src: got %b want %b", name, got_src, e.src); end
    @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_handoff: busy=%b res_valid=%b want 0 0", name, busy, res_valid);
    end
  endtask

  // Serve requests from the operand tables with res_ready high; caller has
  // driven the first operand of each active requester.
  task automatic serve(input int njobs, input int qa, input int qb, output string order);
    exp_t e;
    int ai, bi, done;
    logic pa, pb;
    ai = 0; bi = 0; done = 0;
    order = "";
    for (int cyc = 0; cyc < njobs * (N + 10) + 20 && done < njobs; cyc++) begin
      #1;
      checks++;
      if (a_ready === 1'b1 && b_ready === 1'b1) begin errors++; $display("FAIL both_ready: got 1 1 want at most one"); end
      if (a_valid || b_valid) begin
        checks++;
        if (busy !== !(a_ready || b_ready)) begin
          errors++;
          $display("FAIL busy_between_jobs: got busy=%b want %b", busy, !(a_ready || b_ready));
        end
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got mag %0d want none", res_mag);
        end else begin
          e = sb.pop_front();
          if (res_mag !== e.mag || res_src !== e.src) begin
            errors++;
            $display("FAIL serve_result: got mag %0d src %b want mag %0d src %b", res_mag, res_src, e.mag, e.src);
          end
        end
        done++;
      end
      pa = (a_ready === 1'b1);
      pb = (b_ready === 1'b1);
      if (pa) begin order = {order, "A"}; e.mag = ta_mag[ai]; e.src = 1'b0; sb.push_back(e); ai++; end
      if (pb) begin order = {order, "B"}; e.mag = tb_mag[bi]; e.src = 1'b1; sb.push_back(e); bi++; end
      @(negedge clock);
      if (pa) begin
        if (ai < qa) begin a_re = ta_re[ai]; a_im = ta_im[ai]; end else a_valid = 1'b0;
      end
      if (pb) begin
        if (bi < qb) begin b_re = tb_re[bi]; b_im = tb_im[bi]; end else b_valid = 1'b0;
      end
    end
    checks++;
    if (done != njobs) begin errors++; $display("FAIL serve_done: got %0d want %0d", done, njobs); end
    a_valid = 1'b0;
    b_valid = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
    a_re = 32'd0; a_im = 32'd0; b_re = 32'd0; b_im = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, res_valid, sq_start, sq_stop, a_ready, b_ready, res_src} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {busy, res_valid, sq_start, sq_stop, a_ready, b_ready, res_src});
    end
    checks++;
    if (sq_xin !== 64'd0) begin errors++; $display("FAIL reset_xin: got %h want 0", sq_xin); end
    checks++;
    if (res_mag !== 32'd0) begin errors++; $display("FAIL reset_mag: got %0d want 0", res_mag); end
  endtask

  task automatic test_basic_a();
    run_job(1'b0, 32'd3, 32'd4, 64'd25, 32'd5, "a_3_4");
  endtask

  task automatic test_b_only();
    run_job(1'b1, -32'sd5, -32'sd12, 64'd169, 32'd13, "b_m5_m12");
  endtask

  task automatic test_round_robin();
    string order;
    ta_re[0] = 32'd6;    ta_im[0] = 32'd8;    ta_mag[0] = 32'd10;
    ta_re[1] = -32'sd9;  ta_im[1] = 32'd40;   ta_mag[1] = 32'd41;
    tb_re[0] = 32'd5;    tb_im[0] = 32'd12;   tb_mag[0] = 32'd13;
    tb_re[1] = 32'd8;    tb_im[1] = -32'sd15; tb_mag[1] = 32'd17;
    res_ready = 1'b1;
    a_valid = 1'b1; a_re = ta_re[0]; a_im = ta_im[0];
    b_valid = 1'b1; b_re = tb_re[0]; b_im = tb_im[0];
    serve(4, 2, 2, order);
    checks++;
    if (order != "ABAB") begin errors++; $display("FAIL rr_order: got %s want ABAB", order); end
  endtask

  task automatic test_corners();
    run_job(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000, 32'd3037000499, "min_min");
    run_job(1'b1, 32'd7, 32'd7, 64'd98, 32'd9, "floor_7_7");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int seen, unstable;
    e.mag = 32'd29; e.src = 1'b0;
    sb.push_back(e);
    res_ready = 1'b0;
    a_valid = 1'b1; a_re = 32'd20; a_im = 32'd21;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b want 1", a_ready); end
    @(negedge clock);
    a_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      #1;
      if (res_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL bp_result_timeout: got none want res_valid"); end
    e = sb.pop_front();
    checks++;
    if (res_mag !== e.mag || res_src !== e.src) begin
      errors++;
      $display("FAIL bp_result: got mag %0d src %b want mag %0d src %b", res_mag, res_src, e.mag, e.src);
    end
    a_valid = 1'b1; a_re = 32'd0; a_im = 32'd0;
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1;
      if (res_valid !== 1'b1 || res_mag !== e.mag || res_src !== e.src || a_ready !== 1'b0 || busy !== 1'b1)
        unstable++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
    res_ready = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handoff: got res_valid=%b busy=%b a_ready=%b want 0 0 1", res_valid, busy, a_ready);
    end
    run_job(1'b0, 32'd0, 32'd0, 64'd0, 32'd0, "zero");
  endtask

  task automatic test_reset_in_wait();
    string order;
    int bad;
    res_ready = 1'b1;
    a_valid = 1'b1; a_re = 32'd11; a_im = 32'd60;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b want 1", a_ready); end
    @(negedge clock);
    a_valid = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b1 || sq_start !== 1'b0 || sq_stop !== 1'b0) begin
      errors++;
      $display("FAIL rw_in_wait: got busy=%b start=%b stop=%b want 1 0 0", busy, sq_start, sq_stop);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, sq_start, sq_stop, res_valid} !== 4'b0 || res_mag !== 32'd0 || sq_xin !== 64'd0) begin
      errors++;
      $display("FAIL rw_after_reset: got ctrl=%b mag=%0d xin=%h want 0 0 0",
               {busy, sq_start, sq_stop, res_valid}, res_mag, sq_xin);
    end
    bad = 0;
    for (int k = 0; k < N + 10; k++) begin
      @(negedge clock);
      #1;
      if (sq_stop !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rw_aborted_quiet: got %0d active cycles want 0", bad); end
    ta_re[0] = 32'd1; ta_im[0] = 32'd0;    ta_mag[0] = 32'd1;
    tb_re[0] = 32'd0; tb_im[0] = -32'sd3;  tb_mag[0] = 32'd3;
    a_valid = 1'b1; a_re = ta_re[0]; a_im = ta_im[0];
    b_valid = 1'b1; b_re = tb_re[0]; b_im = tb_im[0];
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL rw_tie: got a_ready=%b b_ready=%b want 1 0", a_ready, b_ready);
    end
    serve(2, 1, 1, order);
    checks++;
    if (order != "AB") begin errors++; $display("FAIL rw_order: got %s want AB", order); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_a();
    test_b_only();
    test_round_robin();
    test_corners();
    test_backpressure();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
